// File: rtl/param_rr_scheduler_pkg.sv
// param_rr_scheduler_pkg: shared defaults and helpers for the scheduler.
// Holds the descriptor width default, destination LSB default and clog2.
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 32
`endif

package param_rr_scheduler_pkg;

  localparam int DISPATCH_W   = `DISPATCH_WIDTH;
  localparam int DEST_LSB_DEF = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_rr_scheduler_fifo.sv
// sched_fifo_sync: show-ahead synchronous FIFO with occupancy count.
// Ports: clk/rst, write (en,data), read (en), head data, count, full, empty.
module sched_fifo_sync
  import param_rr_scheduler_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic [clog2(DEPTH):0] o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_wr;
  logic              do_rd;

  // Full/empty come from the registered count: a same-cycle pop
  // never frees a slot for a write.
  assign o_full    = (count == (AW+1)'(DEPTH));
  assign o_empty   = (count == '0);
  assign o_count   = count;
  assign o_rd_data = mem[rd_ptr];
  assign do_wr     = i_wr_en && !o_full;
  assign do_rd     = i_rd_en && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr && !i_rst) mem[wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/param_rr_scheduler.sv
// param_rr_scheduler: N input queues arbitrated (RR or strict) to one
// crossbar output register with valid/ready, dest select and source id.
module param_rr_scheduler
  import param_rr_scheduler_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = DISPATCH_W,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_OUT    = 4,
  parameter int DEST_LSB   = DEST_LSB_DEF
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic [NUM_PORTS*DATA_W-1:0]               i_wr_data,
  input  logic [NUM_PORTS-1:0]                      i_wr_en,
  output logic [NUM_PORTS-1:0]                      o_full,
  output logic [NUM_PORTS*(clog2(FIFO_DEPTH)+1)-1:0] o_level,
  input  logic                                      i_mode,
  output logic                                      o_cb_valid,
  input  logic                                      i_cb_ready,
  output logic [DATA_W-1:0]                         o_cb_data,
  output logic [clog2(NUM_OUT)-1:0]                 o_cb_sel,
  output logic [clog2(NUM_PORTS)-1:0]               o_cb_src
);

  localparam int LW    = clog2(FIFO_DEPTH) + 1;
  localparam int SEL_W = clog2(NUM_OUT);
  localparam int SRC_W = clog2(NUM_PORTS);

  logic [DATA_W-1:0]    head [NUM_PORTS];
  logic [LW-1:0]        cnt  [NUM_PORTS];
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] empty;
  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 loadable;
  logic                 grant;
  logic [DATA_W-1:0]    gnt_data;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_q
    sched_fifo_sync #(
      .DATA_W(DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_wr_en  (i_wr_en[k]),
      .i_wr_data(i_wr_data[k*DATA_W +: DATA_W]),
      .i_rd_en  (pop[k]),
      .o_rd_data(head[k]),
      .o_count  (cnt[k]),
      .o_full   (o_full[k]),
      .o_empty  (empty[k])
    );
    assign req[k] = !empty[k];
    assign o_level[k*LW +: LW] = cnt[k];
    assign pop[k] = grant && (gnt_idx == SRC_W'(k));
  end

  assign loadable = !o_cb_valid || i_cb_ready;
  assign grant    = loadable && gnt_vld;

  // Scan downward so the last hit is the first port in search order:
  // offset from rr_ptr in RR mode, plain index in strict mode.
  always_comb begin : p_arb
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      idx = i_mode ? i : (int'(rr_ptr) + i) % NUM_PORTS;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_idx == SRC_W'(i)) gnt_data = head[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cb_valid <= 1'b0;
      o_cb_data  <= '0;
      o_cb_sel   <= '0;
      o_cb_src   <= '0;
      rr_ptr     <= '0;
    end else if (loadable) begin
      o_cb_valid <= gnt_vld;
      if (gnt_vld) begin
        o_cb_data <= gnt_data;
        o_cb_sel  <= gnt_data[DEST_LSB +: SEL_W];
        o_cb_src  <= gnt_idx;
        rr_ptr    <= (gnt_idx == SRC_W'(NUM_PORTS-1)) ?
                     '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_rr_scheduler.sv
// tb_param_rr_scheduler: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_param_rr_scheduler;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int LW = 5;

  logic             clk = 0;
  logic             rst;
  logic [NP*DW-1:0] wr_data;
  logic [NP-1:0]    wr_en;
  logic [NP-1:0]    full;
  logic [NP*LW-1:0] level;
  logic             mode;
  logic             cb_valid;
  logic             ready;
  logic [DW-1:0]    cb_data;
  logic [1:0]       cb_sel;
  logic [1:0]       cb_src;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] mq [NP][$];
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_ptr;

  param_rr_scheduler dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_data (wr_data),
    .i_wr_en   (wr_en),
    .o_full    (full),
    .o_level   (level),
    .i_mode    (mode),
    .o_cb_valid(cb_valid),
    .i_cb_ready(ready),
    .o_cb_data (cb_data),
    .o_cb_sel  (cb_sel),
    .o_cb_src  (cb_src)
  );

  always #5 clk = ~clk;

  // One clock edge; the model applies the scheduler rules to the inputs
  // present at that edge, then outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < NP; k++) mq[k].delete();
      m_valid = 0;
      m_data = 0;
      m_src = 0;
      m_ptr = 0;
    end else begin
      bit f [NP];
      int g;
      for (int k = 0; k < NP; k++) f[k] = (mq[k].size() == DEPTH);
      if (!m_valid || ready) begin
        g = -1;
        for (int i = 0; i < NP; i++) begin
          int p;
          p = mode ? i : (m_ptr + i) % NP;
          if (g < 0 && mq[p].size() > 0) g = p;
        end
        if (g >= 0) begin
          m_data = mq[g].pop_front();
          m_src = g;
          m_valid = 1;
          m_ptr = (g + 1) % NP;
        end else begin
          m_valid = 0;
        end
      end
      for (int k = 0; k < NP; k++)
        if (wr_en[k] && !f[k]) mq[k].push_back(wr_data[k*DW +: DW]);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    wr_en = 0;
    tick();
    rst = 0;
  endtask

  function automatic logic [LW-1:0] lvl(input int k);
    logic [NP*LW-1:0] v;
    v = level;
    return v[k*LW +: LW];
  endfunction

  task automatic test_reset();
    mode = 0;
    ready = 0;
    wr_data = 0;
    do_reset();
    n_checks++;
    if (cb_valid !== 1'b0 || cb_data !== 0 || cb_sel !== 0 ||
        cb_src !== 0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b data=%h sel=%0d src=%0d want 0",
               cb_valid, cb_data, cb_sel, cb_src);
    end
    n_checks++;
    if (level !== 0 || full !== 0) begin
      n_fail++;
      $display("FAIL reset_q: level=%h full=%b want 0", level, full);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    ready = 1;
    wr_en = 4'b0100;
    wr_data = 0;
    wr_data[2*DW +: DW] = 32'h0000_000C;
    tick();
    wr_en = 0;
    n_checks++;
    if (cb_valid !== 1'b0 || lvl(2) !== 1) begin
      n_fail++;
      $display("FAIL single_edge0: valid=%b level2=%0d want 0,1",
               cb_valid, lvl(2));
    end
    tick();
    n_checks++;
    if (cb_valid !== 1'b1 || cb_data !== 32'hC || cb_sel !== 2'd3 ||
        cb_src !== 2'd2) begin
      n_fail++;
      $display("FAIL single_edge1: v=%b d=%h sel=%0d src=%0d want 1,c,3,2",
               cb_valid, cb_data, cb_sel, cb_src);
    end
    tick();
    n_checks++;
    if (cb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: valid=%b want 0", cb_valid);
    end
  endtask

  task automatic test_round_robin();
    int seen [NP];
    do_reset();
    mode = 0;
    ready = 0;
    for (int j = 0; j < 3; j++) begin
      wr_en = 4'hF;
      for (int k = 0; k < NP; k++) wr_data[k*DW +: DW] = (k << 8) | j;
      tick();
    end
    wr_en = 0;
    ready = 1;
    for (int k = 0; k < NP; k++) seen[k] = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (cb_valid !== 1'b1 || cb_src !== 2'(i % NP) ||
          cb_data !== DW'(((i % NP) << 8) | seen[i % NP])) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: v=%b src=%0d data=%h want src %0d",
                 i, cb_valid, cb_src, cb_data, i % NP);
      end
      seen[i % NP]++;
    end
    tick();
    n_checks++;
    if (cb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_end: valid=%b want 0", cb_valid);
    end
  endtask

  task automatic test_strict();
    int exp_src [4] = '{0, 0, 3, 3};
    do_reset();
    mode = 1;
    ready = 0;
    for (int j = 0; j < 2; j++) begin
      wr_en = 4'b1001;
      wr_data[0 +: DW] = 32'h100 | j;
      wr_data[3*DW +: DW] = 32'h300 | j;
      tick();
    end
    wr_en = 0;
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (cb_valid !== 1'b1 || cb_src !== 2'(exp_src[i])) begin
        n_fail++;
        $display("FAIL strict_seq[%0d]: v=%b src=%0d want src %0d",
                 i, cb_valid, cb_src, exp_src[i]);
      end
    end
    tick();
    n_checks++;
    if (cb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL strict_end: valid=%b want 0", cb_valid);
    end
    mode = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 0;
    wr_en = 4'b0010;
    wr_data[DW +: DW] = 32'hAAAA_0001;
    tick();
    wr_data[DW +: DW] = 32'hBBBB_0002;
    tick();
    wr_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (cb_valid !== 1'b1 || cb_data !== 32'hAAAA_0001 || lvl(1) !== 1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v=%b data=%h lvl=%0d want 1,aaaa0001,1",
                 i, cb_valid, cb_data, lvl(1));
      end
    end
    ready = 1;
    tick();
    n_checks++;
    if (cb_valid !== 1'b1 || cb_data !== 32'hBBBB_0002 || cb_src !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_next: v=%b data=%h src=%0d want 1,bbbb0002,1",
               cb_valid, cb_data, cb_src);
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    ready = 0;
    wr_en = 4'b0001;
    wr_data[0 +: DW] = 32'hDEAD_0000;
    tick();
    wr_en = 0;
    tick();
    wr_en = 4'b0010;
    for (int i = 0; i < 17; i++) begin
      wr_data[DW +: DW] = 32'h5000 + i;
      tick();
      if (i == 14) begin
        n_checks++;
        if (full[1] !== 1'b0 || lvl(1) !== 15) begin
          n_fail++;
          $display("FAIL full_15: full=%b lvl=%0d want 0,15", full[1], lvl(1));
        end
      end
    end
    wr_en = 0;
    n_checks++;
    if (full[1] !== 1'b1 || lvl(1) !== 16) begin
      n_fail++;
      $display("FAIL full_16: full=%b lvl=%0d want 1,16", full[1], lvl(1));
    end
    ready = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (cb_valid !== 1'b1 || cb_data !== DW'(32'h5000 + i)) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: v=%b data=%h want %h",
                 i, cb_valid, cb_data, 32'h5000 + i);
      end
    end
    tick();
    n_checks++;
    if (cb_valid !== 1'b0 || lvl(1) !== 0) begin
      n_fail++;
      $display("FAIL full_end: v=%b lvl=%0d want 0,0", cb_valid, lvl(1));
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    mode = 0;
    ready = 0;
    wr_en = 4'hF;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < NP; k++) wr_data[k*DW +: DW] = 32'hF0 + k;
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    wr_en = 0;
    n_checks++;
    if (cb_valid !== 0 || cb_data !== 0 || cb_sel !== 0 || cb_src !== 0 ||
        level !== 0 || full !== 0) begin
      n_fail++;
      $display("FAIL mid_reset: v=%b d=%h lvl=%h full=%b want all 0",
               cb_valid, cb_data, level, full);
    end
    tick();
    n_checks++;
    if (cb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_ghost: valid=%b want 0", cb_valid);
    end
    ready = 1;
    wr_en = 4'b1011;
    tick();
    wr_en = 0;
    tick();
    n_checks++;
    if (cb_valid !== 1'b1 || cb_src !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_first: v=%b src=%0d want 1,0", cb_valid, cb_src);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      wr_en = 4'($urandom);
      for (int k = 0; k < NP; k++) wr_data[k*DW +: DW] = $urandom;
      ready = (c < 400) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) mode = ~mode;
      rst = ($urandom_range(199) == 0);
      tick();
      rst = 0;
      n_checks++;
      if (cb_valid !== m_valid || cb_data !== m_data ||
          cb_sel !== m_data[3:2] || (m_valid && cb_src !== 2'(m_src))) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                 c, cb_valid, cb_data, cb_src, m_valid, m_data, m_src);
      end
      for (int k = 0; k < NP; k++) begin
        n_checks++;
        if (lvl(k) !== LW'(mq[k].size()) ||
            full[k] !== (mq[k].size() == DEPTH)) begin
          n_fail++;
          $display("FAIL rand_q[%0d] port %0d: lvl=%0d full=%b want lvl=%0d",
                   c, k, lvl(k), full[k], mq[k].size());
        end
      end
    end
    wr_en = 0;
  endtask

  initial begin
    rst = 1;
    wr_en = 0;
    wr_data = 0;
    mode = 0;
    ready = 0;
    m_valid = 0;
    m_data = 0;
    m_src = 0;
    m_ptr = 0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_strict();
    test_backpressure();
    test_full_drop();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_rr_scheduler.md
PARAM_RR_SCHEDULER -- requirements
Module: param_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of input schedule queues, 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: descriptor width, matching `DISPATCH_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: entries per queue, power of two, at least 2.
REQ-004 SHALL have parameter NUM_OUT, default 4: crossbar output count; SEL_W = clog2(NUM_OUT).
REQ-005 SHALL have parameter DEST_LSB, default 2: LSB of the destination field in the descriptor.
REQ-006 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port i_wr_data, input, NUM_PORTS*DATA_W: per-port descriptor; port k occupies slice [k*DATA_W +: DATA_W].
REQ-009 SHALL have port i_wr_en, input, NUM_PORTS: per-port write strobe.
REQ-010 SHALL have port o_full, output, NUM_PORTS: per-port queue full.
REQ-011 SHALL have port o_level, output, NUM_PORTS*(clog2(FIFO_DEPTH)+1): per-port occupancy.
REQ-012 SHALL have port i_mode, input, 1: arbitration mode; 0 = round-robin, 1 = strict priority (port 0 highest).
REQ-013 SHALL have port o_cb_valid, output, 1: crossbar descriptor valid.
REQ-014 SHALL have port i_cb_ready, input, 1: crossbar accepts the descriptor.
REQ-015 SHALL have port o_cb_data, output, DATA_W: descriptor to the crossbar.
REQ-016 SHALL have port o_cb_sel, output, SEL_W: crossbar destination, equal to o_cb_data[DEST_LSB +: SEL_W].
REQ-017 SHALL have port o_cb_src, output, clog2(NUM_PORTS): source port of the current descriptor.

Function
REQ-018 SHALL accept a write on port k only when i_wr_en[k]=1 and o_full[k]=0; a write while full SHALL be dropped with no state change.
REQ-019 SHALL derive o_full[k] and o_level from the registered count, so a pop in the same cycle does not unblock a write to a full queue.
REQ-020 SHALL keep a queue's count unchanged on a simultaneous accepted write and pop.
REQ-021 SHALL raise a request from queue k whenever its count is nonzero.
REQ-022 SHALL compute a grant combinationally in any cycle where the output register is loadable, i.e. o_cb_valid=0 or i_cb_ready=1.
REQ-023 In mode 0, the grant SHALL go to the first requesting port at or after pointer rr_ptr, searching upward and wrapping from NUM_PORTS-1 to 0.
REQ-024 In mode 1, the grant SHALL go to the lowest-index requesting port.
REQ-025 On a grant to port g, the block SHALL pop queue g and load o_cb_data, o_cb_sel and o_cb_src from g's head in the same cycle, and set o_cb_valid to 1.
REQ-026 On a grant to port g, rr_ptr SHALL become (g+1) mod NUM_PORTS, in both modes.
REQ-027 With no grant, rr_ptr SHALL hold.
REQ-028 When loadable with no requests, o_cb_valid SHALL go to 0.
REQ-029 While o_cb_valid=1 and i_cb_ready=0, o_cb_data, o_cb_sel and o_cb_src SHALL hold stable and no queue SHALL be popped.
REQ-030 Throughput SHALL be one descriptor per cycle under continuous ready.
REQ-031 Latency SHALL be: write accepted at edge t, descriptor on o_cb_* with o_cb_valid=1 after edge t+1 when arbitration is uncontended.
REQ-032 An i_mode change SHALL take effect on the next grant; no descriptor SHALL be lost or duplicated.
REQ-033 Each queue SHALL deliver descriptors in FIFO order; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-034 When i_rst=1 at a clock edge, all queues SHALL be emptied, and o_level, o_full, o_cb_valid, o_cb_data, o_cb_sel, o_cb_src and rr_ptr SHALL be 0.
REQ-035 Writes presented during reset SHALL be discarded, including when reset is asserted mid-stream.

Structure
REQ-036 A shared package SHALL hold the default DATA_W (`DISPATCH_WIDTH), the DEST_LSB default, and a clog2 function.
REQ-037 The block SHALL instantiate NUM_PORTS copies of the sub-module sched_fifo_sync: show-ahead, synchronous reset, count output.
REQ-038 The arbiter and the output register SHALL be inline in this block.

Verification
REQ-039 Single write: after reset, port 2 writes 0x0000_000C at edge 0 -> at edge 1, o_cb_valid=1, o_cb_data=0x0000_000C, o_cb_sel=3, o_cb_src=2.
REQ-040 Round-robin fairness: mode 0, all 4 queues hold 3 entries, ready=1 -> o_cb_src sequence is 0,1,2,3,0,1,2,3,0,1,2,3, then o_cb_valid=0.
REQ-041 Strict priority: mode 1, queues 0 and 3 each hold 2 entries -> o_cb_src sequence is 0,0,3,3.
REQ-042 Backpressure: ready=0 for 5 cycles with valid=1 -> o_cb_data stable and o_level unchanged; on ready=1 the next descriptor follows with no loss.
REQ-043 Full/drop: write 17 descriptors to port 1 with ready=0 and depth 16 -> o_full[1]=1 and o_level=16; the 17th is dropped; the drained sequence is the first 16 in order.
REQ-044 Reset mid-stream: i_rst=1 for 1 cycle while queues are non-empty -> all outputs 0; a subsequent grant starts at port 0.
